// File: rtl/candidate_pair_streamer.sv
// Streams one candidate set per start_gen request: the latched base row, then every
// row with one position pair (p<q) forced to the latched symbol, with tlast on (J-2,J-1).
module candidate_pair_streamer #(
    parameter int J = 14,
    parameter int I = 7,
    parameter int A = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [J*($clog2(A)+1)-1:0]    x_initial,
    input  logic                          x_initial_tvalid,
    input  logic                          start_gen,
    input  logic [$clog2(A):0]            A_value,
    output logic [J*($clog2(A)+1)-1:0]    candidate_row,
    output logic                          candidate_row_tvalid,
    output logic                          candidate_row_tlast,
    input  logic                          candidate_row_tready,
    output logic [$clog2(J):0]            pair_p,
    output logic [$clog2(J):0]            pair_q,
    output logic                          busy,
    output logic                          start_err
);

    localparam int AWIDTH = $clog2(A) + 1;
    localparam int PW     = $clog2(J) + 1;
    localparam int XW     = J * AWIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BASE = 2'd1,
        ST_PAIR = 2'd2
    } state_t;

    state_t              state_r, state_n;
    logic [XW-1:0]       x_r, x_n;
    logic [AWIDTH-1:0]   a_r, a_n;
    logic [PW-1:0]       p_r, p_n;
    logic [PW-1:0]       q_r, q_n;
    logic [XW-1:0]       row_r, row_n;
    logic                tvalid_r, tvalid_n;
    logic                tlast_r, tlast_n;
    logic                busy_r, busy_n;
    logic                err_r, err_n;

    logic                xfer_s;
    logic                a_ok_s;
    logic [XW-1:0]       base_x_s;
    logic [PW-1:0]       p_step_s;
    logic [PW-1:0]       q_step_s;

    // Base vector with symbols p and q overwritten by the forced value
    function automatic logic [XW-1:0] build_row(input logic [XW-1:0]     x,
                                                input logic [AWIDTH-1:0] a,
                                                input logic [PW-1:0]     p,
                                                input logic [PW-1:0]     q);
        logic [XW-1:0] r;
        r = x;
        for (int j = 0; j < J; j++) begin
            if ((PW'(j) == p) || (PW'(j) == q)) begin
                r[j*AWIDTH +: AWIDTH] = a;
            end else begin
                r[j*AWIDTH +: AWIDTH] = x[j*AWIDTH +: AWIDTH];
            end
        end
        return r;
    endfunction

    function automatic logic is_last_pair(input logic [PW-1:0] p, input logic [PW-1:0] q);
        return (p == PW'(J-2)) && (q == PW'(J-1));
    endfunction

    assign xfer_s   = tvalid_r & candidate_row_tready;
    assign a_ok_s   = (int'(A_value) < A);
    assign base_x_s = x_initial_tvalid ? x_initial : x_r;

    // Successor pair in lexicographic (p,q) order
    always_comb begin
        p_step_s = p_r;
        q_step_s = q_r;
        if (q_r < PW'(J-1)) begin
            p_step_s = p_r;
            q_step_s = q_r + PW'(1);
        end else begin
            p_step_s = p_r + PW'(1);
            q_step_s = p_r + PW'(2);
        end
    end

    // Next-state and next-output logic; the next row is built before its transfer
    always_comb begin
        state_n  = state_r;
        x_n      = x_r;
        a_n      = a_r;
        p_n      = p_r;
        q_n      = q_r;
        row_n    = row_r;
        tvalid_n = tvalid_r;
        tlast_n  = tlast_r;
        busy_n   = busy_r;
        err_n    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                x_n = base_x_s;
                if (start_gen) begin
                    if (a_ok_s) begin
                        state_n  = ST_BASE;
                        a_n      = A_value[AWIDTH-1:0];
                        p_n      = {PW{1'b0}};
                        q_n      = {PW{1'b0}};
                        row_n    = base_x_s;
                        tvalid_n = 1'b1;
                        tlast_n  = 1'b0;
                        busy_n   = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_BASE: begin
                err_n = start_gen;
                if (xfer_s) begin
                    state_n = ST_PAIR;
                    p_n     = {PW{1'b0}};
                    q_n     = PW'(1);
                    row_n   = build_row(x_r, a_r, {PW{1'b0}}, PW'(1));
                    tlast_n = is_last_pair({PW{1'b0}}, PW'(1));
                end else begin
                    state_n = ST_BASE;
                end
            end
            ST_PAIR: begin
                err_n = start_gen;
                if (xfer_s && tlast_r) begin
                    state_n  = ST_IDLE;
                    p_n      = {PW{1'b0}};
                    q_n      = {PW{1'b0}};
                    row_n    = {XW{1'b0}};
                    tvalid_n = 1'b0;
                    tlast_n  = 1'b0;
                    busy_n   = 1'b0;
                end else if (xfer_s) begin
                    p_n     = p_step_s;
                    q_n     = q_step_s;
                    row_n   = build_row(x_r, a_r, p_step_s, q_step_s);
                    tlast_n = is_last_pair(p_step_s, q_step_s);
                end else begin
                    state_n = ST_PAIR;
                end
            end
            default: begin
                state_n  = ST_IDLE;
                tvalid_n = 1'b0;
                tlast_n  = 1'b0;
                busy_n   = 1'b0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            x_r      <= {XW{1'b0}};
            a_r      <= {AWIDTH{1'b0}};
            p_r      <= {PW{1'b0}};
            q_r      <= {PW{1'b0}};
            row_r    <= {XW{1'b0}};
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
            busy_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_n;
            x_r      <= x_n;
            a_r      <= a_n;
            p_r      <= p_n;
            q_r      <= q_n;
            row_r    <= row_n;
            tvalid_r <= tvalid_n;
            tlast_r  <= tlast_n;
            busy_r   <= busy_n;
            err_r    <= err_n;
        end
    end

    assign candidate_row        = row_r;
    assign candidate_row_tvalid = tvalid_r;
    assign candidate_row_tlast  = tlast_r;
    assign pair_p               = p_r;
    assign pair_q               = q_r;
    assign busy                 = busy_r;
    assign start_err            = err_r;

endmodule

// File: tb/tb_candidate_pair_streamer.sv
// Randomized bench for candidate_pair_streamer (J=4, A=2) against a queue-based
// model of the candidate set built directly from the pair enumeration rule.
module tb_candidate_pair_streamer;

    localparam int J   = 4;
    localparam int A   = 2;
    localparam int AW  = 2;
    localparam int XW  = 8;
    localparam int PW  = 3;
    localparam int NUM = J * (J - 1) / 2 + 1;

    logic          clk;
    logic          rst_n;
    logic [XW-1:0] x_initial;
    logic          x_initial_tvalid;
    logic          start_gen;
    logic [AW-1:0] A_value;
    logic [XW-1:0] candidate_row;
    logic          candidate_row_tvalid;
    logic          candidate_row_tlast;
    logic          candidate_row_tready;
    logic [PW-1:0] pair_p;
    logic [PW-1:0] pair_q;
    logic          busy;
    logic          start_err;

    int n_checks;
    int n_fail;

    logic [XW-1:0] model_x;
    logic [XW-1:0] exp_row_q[$];
    int            exp_p_q[$];
    int            exp_q_q[$];

    candidate_pair_streamer #(.J(J), .I(7), .A(A)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .x_initial            (x_initial),
        .x_initial_tvalid     (x_initial_tvalid),
        .start_gen            (start_gen),
        .A_value              (A_value),
        .candidate_row        (candidate_row),
        .candidate_row_tvalid (candidate_row_tvalid),
        .candidate_row_tlast  (candidate_row_tlast),
        .candidate_row_tready (candidate_row_tready),
        .pair_p               (pair_p),
        .pair_q               (pair_q),
        .busy                 (busy),
        .start_err            (start_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected set: base row, then each pair p<q with both symbols set to av
    task automatic build_expect(input logic [XW-1:0] xv, input logic [AW-1:0] av);
        logic [AW-1:0] sym[J];
        logic [XW-1:0] r;
        exp_row_q.delete();
        exp_p_q.delete();
        exp_q_q.delete();
        exp_row_q.push_back(xv);
        exp_p_q.push_back(0);
        exp_q_q.push_back(0);
        for (int p = 0; p < J; p++) begin
            for (int q = p + 1; q < J; q++) begin
                for (int k = 0; k < J; k++) sym[k] = xv[k*AW +: AW];
                sym[p] = av;
                sym[q] = av;
                for (int k = 0; k < J; k++) r[k*AW +: AW] = sym[k];
                exp_row_q.push_back(r);
                exp_p_q.push_back(p);
                exp_q_q.push_back(q);
            end
        end
    endtask

    // mode: 0 tready high, 1 pattern 1,0,0,1, 2 random; inject/abort at a row index or -1
    task automatic stream_set(input logic [XW-1:0] xv, input bit load_x, input logic [AW-1:0] av,
                              input int mode, input int inject_at, input int abort_at);
        int  idx;
        bit  done;
        bit  aborted;
        bit  injected;
        bit  err_exp;
        if (load_x) model_x = xv;
        build_expect(model_x, av);
        start_gen        = 1'b1;
        A_value          = av;
        x_initial        = xv;
        x_initial_tvalid = load_x;
        @(negedge clk);
        start_gen        = 1'b0;
        x_initial_tvalid = 1'b0;
        idx = 0; done = 1'b0; aborted = 1'b0; injected = 1'b0; err_exp = 1'b0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            if (abort_at == idx) begin
                rst_n = 1'b0;
                #1;
                check_eq("abort_tvalid", candidate_row_tvalid, 0);
                check_eq("abort_tlast", candidate_row_tlast, 0);
                check_eq("abort_busy", busy, 0);
                model_x = '0;
                @(negedge clk);
                rst_n   = 1'b1;
                aborted = 1'b1;
                done    = 1'b1;
            end else begin
                case (mode)
                    0:       candidate_row_tready = 1'b1;
                    1:       candidate_row_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
                    default: candidate_row_tready = 1'($urandom_range(0, 1));
                endcase
                check_eq("start_err", start_err, err_exp);
                err_exp = 1'b0;
                check_eq("tvalid", candidate_row_tvalid, 1);
                check_eq("busy", busy, 1);
                check_eq("row", candidate_row, exp_row_q[idx]);
                check_eq("tlast", candidate_row_tlast, (idx == NUM - 1));
                check_eq("pair_p", pair_p, exp_p_q[idx]);
                check_eq("pair_q", pair_q, exp_q_q[idx]);
                if (inject_at == idx && !injected) begin
                    start_gen        = 1'b1;
                    A_value          = av;
                    x_initial        = 8'hFF;
                    x_initial_tvalid = 1'b1;
                    injected         = 1'b1;
                    err_exp          = 1'b1;
                end else begin
                    start_gen        = 1'b0;
                    x_initial_tvalid = 1'b0;
                end
                if (candidate_row_tready) begin
                    if (idx == NUM - 1) done = 1'b1;
                    idx++;
                end
                @(negedge clk);
            end
        end
        start_gen        = 1'b0;
        x_initial_tvalid = 1'b0;
        if (!aborted) begin
            check_eq("set_done", done, 1);
            check_eq("end_tvalid", candidate_row_tvalid, 0);
            check_eq("end_busy", busy, 0);
            check_eq("end_start_err", start_err, err_exp);
        end
    endtask

    task automatic bad_start(input logic [AW-1:0] av);
        start_gen = 1'b1;
        A_value   = av;
        @(negedge clk);
        start_gen = 1'b0;
        check_eq("bad_start_err", start_err, 1);
        check_eq("bad_tvalid", candidate_row_tvalid, 0);
        check_eq("bad_busy", busy, 0);
        @(negedge clk);
        check_eq("bad_err_clear", start_err, 0);
        check_eq("bad_tvalid2", candidate_row_tvalid, 0);
    endtask

    task automatic load_only(input logic [XW-1:0] xv);
        x_initial        = xv;
        x_initial_tvalid = 1'b1;
        @(negedge clk);
        x_initial_tvalid = 1'b0;
        model_x          = xv;
        check_eq("load_idle_tvalid", candidate_row_tvalid, 0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_x  = '0;
        rst_n = 1'b0;
        x_initial = '0;
        x_initial_tvalid = 1'b0;
        start_gen = 1'b0;
        A_value = '0;
        candidate_row_tready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_tvalid", candidate_row_tvalid, 0);
        check_eq("rst_tlast", candidate_row_tlast, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_row", candidate_row, 0);
        check_eq("rst_err", start_err, 0);
        check_eq("rst_pair", {pair_p, pair_q}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        stream_set(8'h00, 1'b1, 2'd1, 0, -1, -1);
        stream_set(8'h00, 1'b1, 2'd1, 1, -1, -1);
        stream_set(8'h55, 1'b1, 2'd0, 0, -1, -1);
        stream_set(8'h55, 1'b0, 2'd1, 0, -1, -1);
        bad_start(2'd2);
        bad_start(2'd3);
        stream_set(8'h1B, 1'b1, 2'd1, 1, 3, -1);
        stream_set(8'h00, 1'b0, 2'd0, 0, -1, -1);
        stream_set(8'hFF, 1'b1, 2'd0, 0, -1, -1);
        stream_set(8'hA6, 1'b1, 2'd1, 0, 6, -1);
        stream_set(8'h33, 1'b1, 2'd1, 1, -1, 4);
        stream_set(8'h00, 1'b0, 2'd1, 0, -1, -1);
        load_only(8'h9C);
        stream_set(8'h00, 1'b0, 2'd0, 2, -1, -1);

        for (int n = 0; n < 12; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                bad_start(AW'($urandom_range(2, 3)));
            end else begin
                stream_set(XW'($urandom), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 1)),
                           2, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NUM - 1)) : -1, -1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
